sram_arbiter: RTL

//  Shares the single external 8-bit asynchronous SRAM between three requesters:
//  the ROM bootstrap loader, the video fetch path, and the CPU/ROM-paged path.

---
 rtl/sram_arbiter_pkg.sv | 40 ++++
 rtl/sram_arb_pick.sv | 30 +++
 rtl/sram_arbiter.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/sram_arbiter_pkg.sv
// Shared types and constants for the SRAM arbiter: FSM states, port ids,
// access timing and the latched access record.
package sram_arbiter_pkg;

    localparam int unsigned ADDR_W       = 18;
    localparam int unsigned DATA_W       = 8;
    localparam int unsigned SETUP_CYC    = 1;
    localparam int unsigned STROBE_CYC   = 3;
    localparam int unsigned HOLD_CYC     = 1;
    localparam int unsigned STARVE_LIMIT = 8;
    localparam int unsigned N_PORTS      = 3;
    localparam int unsigned PH_W         = 2;
    localparam int unsigned STARVE_W     = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_STROBE = 2'd2,
        ST_HOLD   = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        PORT_BOOT = 2'd0,
        PORT_VID  = 2'd1,
        PORT_CPU  = 2'd2
    } port_t;

    typedef struct packed {
        port_t             port;
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } sram_xfer_t;

    // One-hot mask for a port id
    function automatic logic [N_PORTS-1:0] port_mask(input port_t p);
        return N_PORTS'(1) << p;
    endfunction

endpackage

// File: rtl/sram_arb_pick.sv
// Combinational priority picker: boot > video > cpu, with a starving cpu
// promoted above video. Excluded ports never win.
module sram_arb_pick
    import sram_arbiter_pkg::*;
(
    input  logic [N_PORTS-1:0] i_req,
    input  logic [N_PORTS-1:0] i_excl,
    input  logic               i_starve,
    output logic [N_PORTS-1:0] o_grant_c
);

    logic [N_PORTS-1:0] w_req;

    assign w_req = i_req & ~i_excl;

    // Fixed priority with starvation override of video by cpu
    always_comb begin
        o_grant_c = '0;
        if (w_req[PORT_BOOT]) begin
            o_grant_c = port_mask(PORT_BOOT);
        end else if (i_starve && w_req[PORT_CPU]) begin
            o_grant_c = port_mask(PORT_CPU);
        end else if (w_req[PORT_VID]) begin
            o_grant_c = port_mask(PORT_VID);
        end else if (w_req[PORT_CPU]) begin
            o_grant_c = port_mask(PORT_CPU);
        end
    end

endmodule

// File: rtl/sram_arbiter.sv
// Three-port arbiter for the external asynchronous SRAM. Every access runs a
// fixed SETUP/STROBE/HOLD sequence; all pad controls come straight from flops.
module sram_arbiter
    import sram_arbiter_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              boot_req,
    input  logic              boot_we,
    input  logic [ADDR_W-1:0] boot_addr,
    input  logic [DATA_W-1:0] boot_wdata,
    output logic              boot_ack,
    input  logic              vid_req,
    input  logic [ADDR_W-1:0] vid_addr,
    output logic [DATA_W-1:0] vid_rdata,
    output logic              vid_ack,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ack,
    output logic              sram_cs_b,
    output logic              sram_oe_b,
    output logic              sram_we_b,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_dout,
    output logic              sram_dout_en,
    input  logic [DATA_W-1:0] sram_din
);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [PH_W-1:0]    r_phase;
    logic [PH_W-1:0]    w_phase_nxt;
    logic               w_arb;
    sram_xfer_t         r_cur;
    sram_xfer_t         w_sel;
    logic [N_PORTS-1:0] w_req;
    logic [N_PORTS-1:0] w_excl;
    logic [N_PORTS-1:0] w_grant;
    logic [N_PORTS-1:0] w_take;
    logic               w_load;
    logic               w_we_nxt;
    logic               w_starve;
    logic [STARVE_W-1:0] r_starve;
    logic               r_cs_b;
    logic               r_oe_b;
    logic               r_we_b;
    logic               r_dout_en;
    logic [N_PORTS-1:0] r_ack;
    logic [DATA_W-1:0]  r_vid_rdata;
    logic [DATA_W-1:0]  r_cpu_rdata;

    assign w_req    = {cpu_req, vid_req, boot_req};
    assign w_excl   = (r_state == ST_HOLD) ? port_mask(r_cur.port) : '0;
    assign w_starve = (r_starve >= STARVE_W'(STARVE_LIMIT));
    assign w_take   = w_arb ? w_grant : '0;
    assign w_load   = |w_take;
    assign w_we_nxt = w_load ? w_sel.we : r_cur.we;

    sram_arb_pick u_pick (
        .i_req     (w_req),
        .i_excl    (w_excl),
        .i_starve  (w_starve),
        .o_grant_c (w_grant)
    );

    // State and phase register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
            r_phase <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_phase <= w_phase_nxt;
        end
    end

    // Next state; arbitration window is IDLE and the last HOLD clock
    always_comb begin
        w_state_nxt = r_state;
        w_phase_nxt = r_phase;
        w_arb       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_arb = 1'b1;
                if (|w_grant) begin
                    w_state_nxt = ST_SETUP;
                    w_phase_nxt = '0;
                end
            end
            ST_SETUP: begin
                if (r_phase == PH_W'(SETUP_CYC - 1)) begin
                    w_state_nxt = ST_STROBE;
                    w_phase_nxt = '0;
                end else begin
                    w_phase_nxt = r_phase + PH_W'(1);
                end
            end
            ST_STROBE: begin
                if (r_phase == PH_W'(STROBE_CYC - 1)) begin
                    w_state_nxt = ST_HOLD;
                    w_phase_nxt = '0;
                end else begin
                    w_phase_nxt = r_phase + PH_W'(1);
                end
            end
            ST_HOLD: begin
                if (r_phase == PH_W'(HOLD_CYC - 1)) begin
                    w_arb       = 1'b1;
                    w_state_nxt = (|w_grant) ? ST_SETUP : ST_IDLE;
                    w_phase_nxt = '0;
                end else begin
                    w_phase_nxt = r_phase + PH_W'(1);
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_phase_nxt = '0;
            end
        endcase
    end

    // Request fields of the granted port; video has no write path
    always_comb begin
        w_sel = '0;
        if (w_take[PORT_BOOT]) begin
            w_sel.port  = PORT_BOOT;
            w_sel.we    = boot_we;
            w_sel.addr  = boot_addr;
            w_sel.wdata = boot_wdata;
        end else if (w_take[PORT_VID]) begin
            w_sel.port  = PORT_VID;
            w_sel.we    = 1'b0;
            w_sel.addr  = vid_addr;
            w_sel.wdata = DATA_W'(0);
        end else if (w_take[PORT_CPU]) begin
            w_sel.port  = PORT_CPU;
            w_sel.we    = cpu_we;
            w_sel.addr  = cpu_addr;
            w_sel.wdata = cpu_wdata;
        end
    end

    // Latched access, pad strobes and acks, all decoded from the next state
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cur     <= '0;
            r_cs_b    <= 1'b1;
            r_oe_b    <= 1'b1;
            r_we_b    <= 1'b1;
            r_dout_en <= 1'b0;
            r_ack     <= '0;
        end else begin
            if (w_load) begin
                r_cur <= w_sel;
            end
            r_cs_b    <= (w_state_nxt == ST_IDLE);
            r_oe_b    <= !(((w_state_nxt == ST_SETUP) || (w_state_nxt == ST_STROBE)) && !w_we_nxt);
            r_we_b    <= !((w_state_nxt == ST_STROBE) && w_we_nxt);
            r_dout_en <= (w_state_nxt != ST_IDLE) && w_we_nxt;
            r_ack     <= '0;
            if ((w_state_nxt == ST_HOLD) && (w_phase_nxt == PH_W'(HOLD_CYC - 1))) begin
                r_ack <= port_mask(r_cur.port);
            end
        end
    end

    // Capture read data at the closing edge of the strobe window
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_vid_rdata <= '0;
            r_cpu_rdata <= '0;
        end else if ((r_state == ST_STROBE) && (r_phase == PH_W'(STROBE_CYC - 1)) && !r_cur.we) begin
            if (r_cur.port == PORT_VID) begin
                r_vid_rdata <= sram_din;
            end
            if (r_cur.port == PORT_CPU) begin
                r_cpu_rdata <= sram_din;
            end
        end
    end

    // Cpu starvation counter: counts waiting clocks, saturating
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_starve <= '0;
        end else if (!cpu_req || w_take[PORT_CPU]) begin
            r_starve <= '0;
        end else if (!w_starve) begin
            r_starve <= r_starve + STARVE_W'(1);
        end
    end

    assign boot_ack     = r_ack[PORT_BOOT];
    assign vid_ack      = r_ack[PORT_VID];
    assign cpu_ack      = r_ack[PORT_CPU];
    assign vid_rdata    = r_vid_rdata;
    assign cpu_rdata    = r_cpu_rdata;
    assign sram_cs_b    = r_cs_b;
    assign sram_oe_b    = r_oe_b;
    assign sram_we_b    = r_we_b;
    assign sram_addr    = r_cur.addr;
    assign sram_dout    = r_cur.wdata;
    assign sram_dout_en = r_dout_en;

endmodule
